// File: rtl/keymatrix_pkg.sv
// Shared definitions for the keyboard matrix engine: FSM states, default
// Vector-06C geometry and the width helper used to derive port widths.
package keymatrix_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  typedef enum logic [2:0] {
    S_CLR,
    S_SCAN,
    S_RD,
    S_MOD,
    S_WR
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/keymatrix_ram_p.sv
// Single-port ROWS x COLS synchronous RAM, 1-cycle read latency.
// Read data holds its previous value on write cycles.
module keymatrix_ram_p
  import keymatrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = clog2(ROWS)
) (
  input  logic            clkk,
  input  logic            en,
  input  logic            we,
  input  logic [RW-1:0]   addr,
  input  logic [COLS-1:0] wdata,
  output logic [COLS-1:0] rdata
);

  logic [COLS-1:0] mem_q [ROWS];
  logic [COLS-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset; the engine rewrites
  // every row after reset, and a reset net would prevent RAM inference.
  always_ff @(posedge clkk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/keymatrix_engine.sv
// Key matrix store with make/break event intake, bulk clear, key counting
// and a continuous row sweep producing the CPU column readback word.
module keymatrix_engine
  import keymatrix_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RW   = clog2(ROWS),
  parameter int CW   = clog2(COLS),
  parameter int NW   = clog2(ROWS * COLS + 1)
) (
  input  logic            clkk,
  input  logic            reset_n,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic            ev_make,
  input  logic [RW-1:0]   ev_row,
  input  logic [CW-1:0]   ev_col,
  input  logic            clr_req,
  input  logic [ROWS-1:0] rowselect,
  output logic [COLS-1:0] rowbits,
  output logic [NW-1:0]   key_count,
  output logic            any_key,
  output logic            chg,
  output logic            err
);

  localparam int KW      = clog2(ROWS + 1);
  localparam int ROWS_M1 = ROWS - 1;
  localparam logic [KW-1:0] K_LAST    = ROWS[KW-1:0];
  localparam logic [KW-1:0] K_CLR_END = ROWS_M1[KW-1:0];
  localparam logic [RW:0]   ROW_LIM   = ROWS[RW:0];
  localparam logic [CW:0]   COL_LIM   = COLS[CW:0];

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            clr_pend_q, clr_pend_d;
  logic            make_q, make_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] accu_q, accu_d;
  logic [COLS-1:0] new_q, new_d;
  logic [COLS-1:0] rowbits_q, rowbits_d;
  logic [NW-1:0]   key_count_q, key_count_d;
  logic            any_key_q, any_key_d;
  logic            chg_q, chg_d;
  logic            err_q, err_d;

  logic            ram_en, ram_we;
  logic [RW-1:0]   ram_addr;
  logic [COLS-1:0] ram_wdata, ram_q;

  logic            clr_now, row_hit, ev_oor;
  logic [RW-1:0]   sel_row;
  logic [COLS-1:0] col_mask, mod_new, accu_next;

  keymatrix_ram_p #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_ram (
    .clkk  (clkk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // NOTE: every signal written here gets a default first so that no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    clr_pend_d  = clr_pend_q | clr_req;
    make_d      = make_q;
    row_d       = row_q;
    col_d       = col_q;
    accu_d      = accu_q;
    new_d       = new_q;
    rowbits_d   = rowbits_q;
    key_count_d = key_count_q;
    chg_d       = 1'b0;
    err_d       = 1'b0;
    ev_ready    = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = k_q[RW-1:0];
    ram_wdata   = '0;

    // A clear requested this very cycle also wins the sweep boundary.
    clr_now   = clr_pend_q | clr_req;
    sel_row   = RW'(k_q - KW'(1));
    row_hit   = (k_q != '0) && rowselect[sel_row];
    accu_next = accu_q | (row_hit ? ram_q : '0);
    col_mask  = {{(COLS-1){1'b0}}, 1'b1} << col_q;
    mod_new   = make_q ? (ram_q | col_mask) : (ram_q & ~col_mask);
    ev_oor    = ({1'b0, ev_row} >= ROW_LIM) || ({1'b0, ev_col} >= COL_LIM);

    unique case (state_q)
      S_CLR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        clr_pend_d = 1'b0;
        if (k_q == K_CLR_END) begin
          state_d     = S_SCAN;
          k_d         = '0;
          key_count_d = '0;
          rowbits_d   = '0;
          accu_d      = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_SCAN: begin
        if (k_q != K_LAST) begin
          ram_en = 1'b1;
          accu_d = accu_next;
          k_d    = k_q + KW'(1);
        end else begin
          rowbits_d = accu_next;
          accu_d    = '0;
          k_d       = '0;
          ev_ready  = !clr_now;
          if (clr_now) begin
            state_d    = S_CLR;
            clr_pend_d = 1'b0;
          end else if (ev_valid) begin
            make_d = ev_make;
            row_d  = ev_row;
            col_d  = ev_col;
            if (ev_oor) err_d   = 1'b1;
            else        state_d = S_RD;
          end
        end
      end

      S_RD: begin
        ram_en   = 1'b1;
        ram_addr = row_q;
        state_d  = S_MOD;
      end

      S_MOD: begin
        new_d   = mod_new;
        state_d = S_WR;
        // Only a real bit flip moves the count, so it can never wrap.
        if (mod_new != ram_q) begin
          chg_d       = 1'b1;
          key_count_d = make_q ? key_count_q + NW'(1) : key_count_q - NW'(1);
        end
      end

      S_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = row_q;
        ram_wdata = new_q;
        state_d   = S_SCAN;
        k_d       = '0;
      end

      default: begin
        state_d = S_CLR;
        k_d     = '0;
      end
    endcase

    any_key_d = (key_count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones
  // here would let later flops see this edge's new values.
  always_ff @(posedge clkk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLR;
      k_q         <= '0;
      clr_pend_q  <= 1'b0;
      make_q      <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      accu_q      <= '0;
      new_q       <= '0;
      rowbits_q   <= '0;
      key_count_q <= '0;
      any_key_q   <= 1'b0;
      chg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      clr_pend_q  <= clr_pend_d;
      make_q      <= make_d;
      row_q       <= row_d;
      col_q       <= col_d;
      accu_q      <= accu_d;
      new_q       <= new_d;
      rowbits_q   <= rowbits_d;
      key_count_q <= key_count_d;
      any_key_q   <= any_key_d;
      chg_q       <= chg_d;
      err_q       <= err_d;
    end
  end

  assign rowbits   = rowbits_q;
  assign key_count = key_count_q;
  assign any_key   = any_key_q;
  assign chg       = chg_q;
  assign err       = err_q;

endmodule
